// File: rtl/gate_sweep_tester.sv
// Exhaustive-stimulus sweep engine: applies every input vector to a small gate, captures its truth table
// and compares it against an expected table. Optional CRC-16 response signature under GATE_SWEEP_MISR_EN.
module gate_sweep_tester #(
   parameter int N_IN = 2,
   parameter int HOLD = 4,
   parameter int TT_W = 2**N_IN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [TT_W-1:0]  exp_table,
   input  logic             dut_out,
   output logic [N_IN-1:0]  dut_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [TT_W-1:0]  truth_table,
   output logic [15:0]      signature
);

   localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
   localparam logic [N_IN:0]   VEC_LAST  = (N_IN+1)'(TT_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [N_IN:0]     vec_q;
   logic [HC_W-1:0]   hold_cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [TT_W-1:0]   tt_q;
   logic [TT_W-1:0]   tt_d;
   logic              sample_d;
   logic              last_d;
   logic              accept_d;

   // tt_d folds the current sample in so the final compare sees it on the same edge
   always_comb begin
      tt_d = tt_q;
      tt_d[vec_q[N_IN-1:0]] = dut_out;
      sample_d = (state_q == S_APPLY) && (hold_cnt_q == HOLD_LAST);
      last_d   = (vec_q == VEC_LAST);
      accept_d = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         hold_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         tt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_APPLY;
                  tt_q       <= '0;
                  pass_q     <= 1'b0;
                  done_q     <= 1'b0;
                  vec_q      <= '0;
                  hold_cnt_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_APPLY: begin
               if (sample_d) begin
                  tt_q       <= tt_d;
                  hold_cnt_q <= '0;
                  if (last_d) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (tt_d == exp_table);
                  end else begin
                     vec_q <= vec_q + 1'b1;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef GATE_SWEEP_MISR_EN
   logic [15:0] sig_q;
   logic [15:0] sig_d;

   always_comb begin
      sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ dut_out) ? 16'h1021 : 16'h0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (accept_d) begin
         sig_q <= 16'hFFFF;
      end else if (sample_d) begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

   assign dut_in      = vec_q[N_IN-1:0];
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign truth_table = tt_q;

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Directed bench for gate_sweep_tester: AND/XOR sweeps at N_IN=2/HOLD=4, ignored restart, mid-sweep
// reset, and a majority sweep at N_IN=3/HOLD=1.
module tb_gate_sweep_tester;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start2;
   logic [3:0]  exp2;
   logic        dut_out2;
   logic [1:0]  dut_in2;
   logic        busy2, done2, pass2;
   logic [3:0]  tt2;
   logic [15:0] sig2;
   int          gate2;

   logic        start3;
   logic [7:0]  exp3;
   logic        dut_out3;
   logic [2:0]  dut_in3;
   logic        busy3, done3, pass3;
   logic [7:0]  tt3;
   logic [15:0] sig3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign dut_out2 = (gate2 == 0) ? (dut_in2[0] & dut_in2[1]) : (dut_in2[0] ^ dut_in2[1]);
   assign dut_out3 = (dut_in3[0] & dut_in3[1]) | (dut_in3[0] & dut_in3[2]) | (dut_in3[1] & dut_in3[2]);

   gate_sweep_tester #(.N_IN(2), .HOLD(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .exp_table(exp2), .dut_out(dut_out2),
      .dut_in(dut_in2), .busy(busy2), .done(done2), .pass(pass2), .truth_table(tt2), .signature(sig2)
   );

   gate_sweep_tester #(.N_IN(3), .HOLD(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .exp_table(exp3), .dut_out(dut_out3),
      .dut_in(dut_in3), .busy(busy3), .done(done3), .pass(pass3), .truth_table(tt3), .signature(sig3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
      return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   function automatic logic [15:0] exp_sig(input logic [7:0] bits, input int n);
      logic [15:0] s;
`ifdef GATE_SWEEP_MISR_EN
      s = 16'hFFFF;
      for (int i = 0; i < n; i++) s = crc_step(s, bits[i]);
`else
      s = 16'h0000;
`endif
      return s;
   endfunction

   // Full N_IN=2/HOLD=4 sweep; start accepted at edge k, optional extra start pulse at edge k+pulse_at.
   task automatic run2(input string nm, input int mode, input logic [3:0] exp_tab,
                       input int pulse_at, input logic [3:0] exp_tt, input logic exp_pass);
      gate2 = mode;
      exp2  = ~exp_tab;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      check_eq({nm, ".k.busy"}, 32'(busy2), 32'd1);
      check_eq({nm, ".k.done"}, 32'(done2), 32'd0);
      check_eq({nm, ".k.tt"}, 32'(tt2), 32'd0);
      check_eq({nm, ".k.dut_in"}, 32'(dut_in2), 32'd0);
      for (int m = 1; m <= 15; m++) begin
         start2 = (m == pulse_at);
         @(posedge clk); #1;
         if (m == 15) exp2 = exp_tab;
         check_eq($sformatf("%s.dut_in@%0d", nm, m), 32'(dut_in2), 32'(m / 4));
         check_eq($sformatf("%s.busy@%0d", nm, m), 32'(busy2), 32'd1);
      end
      start2 = 1'b0;
      @(posedge clk); #1;
      check_eq({nm, ".done"}, 32'(done2), 32'd1);
      check_eq({nm, ".busy_end"}, 32'(busy2), 32'd0);
      check_eq({nm, ".tt"}, 32'(tt2), 32'(exp_tt));
      check_eq({nm, ".pass"}, 32'(pass2), 32'(exp_pass));
      check_eq({nm, ".dut_in_end"}, 32'(dut_in2), 32'd3);
      check_eq({nm, ".sig"}, 32'(sig2), 32'(exp_sig({4'b0, exp_tt}, 4)));
      exp2 = 4'b0000;
      @(posedge clk); #1;
      check_eq({nm, ".done_held"}, 32'(done2), 32'd1);
      check_eq({nm, ".pass_held"}, 32'(pass2), 32'(exp_pass));
   endtask

   initial begin
      rst_n  = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
      exp2   = 4'b0000;
      exp3   = 8'hE8;
      gate2  = 0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.dut_in", 32'(dut_in2), 32'd0);
      check_eq("rst.busy", 32'(busy2), 32'd0);
      check_eq("rst.done", 32'(done2), 32'd0);
      check_eq("rst.pass", 32'(pass2), 32'd0);
      check_eq("rst.tt", 32'(tt2), 32'd0);
      check_eq("rst.sig", 32'(sig2), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("idle.busy", 32'(busy2), 32'd0);

      run2("and", 0, 4'b1000, -1, 4'b1000, 1'b1);
      run2("xor", 1, 4'b1000, -1, 4'b0110, 1'b0);
      run2("and_restart", 0, 4'b1000, 8, 4'b1000, 1'b1);

      // Abort mid-sweep once vec reaches 2
      gate2 = 0;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_eq("abort.pre_vec", 32'(dut_in2), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort.dut_in", 32'(dut_in2), 32'd0);
      check_eq("abort.busy", 32'(busy2), 32'd0);
      check_eq("abort.done", 32'(done2), 32'd0);
      check_eq("abort.tt", 32'(tt2), 32'd0);
      check_eq("abort.sig", 32'(sig2), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run2("after_rst", 0, 4'b1000, -1, 4'b1000, 1'b1);

      // Majority gate, N_IN=3, HOLD=1
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      for (int m = 0; m <= 7; m++) begin
         if (m > 0) begin
            @(posedge clk); #1;
         end
         check_eq($sformatf("maj.dut_in@%0d", m), 32'(dut_in3), 32'(m));
         check_eq($sformatf("maj.done@%0d", m), 32'(done3), 32'd0);
      end
      @(posedge clk); #1;
      check_eq("maj.done", 32'(done3), 32'd1);
      check_eq("maj.busy", 32'(busy3), 32'd0);
      check_eq("maj.tt", 32'(tt3), 32'hE8);
      check_eq("maj.pass", 32'(pass3), 32'd1);
      check_eq("maj.dut_in_end", 32'(dut_in3), 32'd7);
      check_eq("maj.sig", 32'(sig3), 32'(exp_sig(8'hE8, 8)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_sweep_tester.md
Name: gate_sweep_tester

Overview:
- Synthesizable exhaustive-stimulus engine for small combinational gates under test (DUT).
- Drives every input combination 0 .. 2^N_IN-1 in ascending order and holds each for HOLD cycles.
- Captures the DUT output into a truth-table register and compares it against an expected table.
- Used for on-board/self-test sweeps; replaces hand-written per-gate stimulus sequences.

Parameters:
- N_IN, 2, DUT input count; legal 1..8.
- HOLD, 4, clock cycles each vector is held before sampling; legal >= 1.
- TT_W, 2**N_IN, truth-table width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep; sampled in IDLE or DONE only
- exp_table  in  TT_W  expected DUT output; bit i = expected F for input vector i
- dut_out  in  1  DUT response (F)
- dut_in  out  N_IN  vector applied to the DUT
- busy  out  1  sweep in progress
- done  out  1  sweep finished; level, held until the next accepted start
- pass  out  1  valid while done=1; 1 iff truth_table == exp_table
- truth_table  out  TT_W  captured response; bit i = dut_out sampled for vector i
- signature  out  16  response signature (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - dut_in=0, busy=0, done=0, pass=0, truth_table=0, signature=0
  - hold_cnt=0, vec=0
  - Reset mid-sweep aborts the sweep immediately; nothing is retained.
- FSM states: IDLE, APPLY, DONE.
- IDLE/DONE, start=1 at edge k:
  - Clear truth_table, pass, done; vec=0, dut_in=0, hold_cnt=0; busy=1; go to APPLY.
  - With start=0, stay in the current state.
- APPLY:
  - dut_in always equals vec.
  - hold_cnt increments each edge.
  - When hold_cnt==HOLD-1 at an edge: truth_table[vec] <= dut_out; hold_cnt <= 0.
    - If vec==TT_W-1: go to DONE; busy=0, done=1, pass <= ({dut_out, truth_table[TT_W-2:0]} == exp_table). The compare uses the final sample in the same edge.
    - Else: vec <= vec+1 (dut_in updates the same edge).
- Timing:
  - The sample for vector i occurs at edge k+(i+1)*HOLD.
  - done rises at edge k+TT_W*HOLD; N_IN=2, HOLD=4 gives 16 cycles.
  - HOLD=1: each vector is applied for exactly one cycle and sampled at the next edge.
- start while busy=1 is ignored; no restart and no queueing.
- exp_table is sampled only at the final compare edge; changes during the sweep are legal.
- dut_in remains at TT_W-1 in DONE until the next start.
- vec width is N_IN+1 bits internally; no wrap occurs before the DONE transition.

Optional Feature:
- Macro: GATE_SWEEP_MISR_EN.
- Defined:
  - signature is a serial CRC-16-CCITT (poly 0x1021) over the sampled dut_out bits.
  - Seeded to 16'hFFFF on accepted start.
  - Each sample edge: sig <= {sig[14:0],1'b0} ^ ((sig[15]^dut_out) ? 16'h1021 : 16'h0000).
  - Holds its value in DONE.
- Undefined: signature is tied to 16'h0000; no CRC logic is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- N_IN=2, HOLD=4, DUT=AND, exp_table=4'b1000, start at edge k:
  - dut_in sequence 0,1,2,3 with 4 cycles each.
  - done=1 at k+16, truth_table=4'b1000, pass=1, busy=0.
- Same setup, DUT=XOR, exp_table=4'b1000 -> truth_table=4'b0110, pass=0.
- Pulse start again at k+8 during an AND sweep -> ignored: vec continues 2,3 and done still rises at k+16.
- Drop rst_n at vec=2 mid-sweep -> all outputs 0 asynchronously; a new start gives a full 16-cycle sweep with the correct table.
- N_IN=3, HOLD=1, DUT=majority, exp_table=8'hE8 -> done at k+8, truth_table=8'b11101000, pass=1.
- GATE_SWEEP_MISR_EN defined, AND sweep -> signature equals the bench CRC model over bits 0,0,0,1. Undefined build -> signature=0 throughout.
